instrfetch: RTL



---
 rtl/mips_pkg.sv | 32 +++
 rtl/instrfetch_instrmem.sv | 31 +++
 rtl/instrfetch.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and opcode constants for the instruction fetch
//               sequencer and the CPU control path.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    // Primary opcode field values (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_HALT  = 6'd63;

    // Extract the primary opcode from an instruction word
    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instrfetch_instrmem.sv
`default_nettype none
// ============================================================================
// Module      : instrmem
// Description : DEPTH x 32 instruction RAM, one synchronous read port with
//               1-cycle latency and one write port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instrmem #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Write on the sampling edge; read is registered (old data on collision)
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/instrfetch.sv
`default_nettype none
// ============================================================================
// Module      : instrfetch
// Description : Instruction fetch sequencer. Holds the PC and instruction
//               memory, presents one word at a time on instrword with a
//               one-cycle newinstr pulse, holds it for DWELL cycles, then
//               advances the PC. Optional beq support is enabled by defining
//               the macro INSTRFETCH_BRANCH_EN (adds the alu_zero port).
// Revision    : 1.0 - initial release
// ============================================================================
module instrfetch
    import mips_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int PCW   = 7,
    parameter int DWELL = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           prog_we,
    input  logic [PCW-1:0] prog_addr,
    input  logic [31:0]    prog_data,
`ifdef INSTRFETCH_BRANCH_EN
    input  logic           alu_zero,
`endif
    output logic [31:0]    instrword,
    output logic           newinstr,
    output logic [PCW-1:0] pc,
    output logic           busy,
    output logic           halted
);

    localparam logic [3:0]     c_dwell_last = 4'(DWELL - 1);
    localparam logic [PCW-1:0] c_pc_one     = PCW'(1);

    fetch_state_t   r_state;
    logic [3:0]     r_cnt;
    logic [PCW-1:0] r_pc;
    logic [31:0]    r_instrword;
    logic           r_newinstr;
    logic           r_busy;
    logic           r_halted;

    logic [PCW-1:0] w_pc_inc;
    logic [PCW-1:0] w_pc_adv;
    logic [PCW-1:0] w_pc_next;
    logic           w_mem_we;
    logic [31:0]    w_rdata;

    assign w_pc_inc = r_pc + c_pc_one;

`ifdef INSTRFETCH_BRANCH_EN
    // Taken beq: offset is the low PCW bits of the immediate, wrapping mod DEPTH
    assign w_pc_adv = (opcode_of(r_instrword) == OP_BEQ && alu_zero)
                    ? (w_pc_inc + r_instrword[PCW-1:0])
                    : w_pc_inc;
`else
    assign w_pc_adv = w_pc_inc;
`endif

    // Value the PC takes at the next edge; also drives the RAM read address so
    // the word is already registered when FETCH inspects it.
    always_comb begin
        w_pc_next = r_pc;
        case (r_state)
            HALT:    if (start) w_pc_next = '0;
            WAIT:    if (r_cnt == c_dwell_last) w_pc_next = w_pc_adv;
            default: w_pc_next = r_pc;
        endcase
    end

    // Program loads only land while the sequencer is parked
    assign w_mem_we = prog_we && ((r_state == IDLE) || (r_state == HALT));

    instrmem #(
        .DEPTH (DEPTH),
        .AW    (PCW)
    ) u_instrmem (
        .clk     (clock),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (w_pc_next),
        .o_rdata (w_rdata)
    );

    // Sequencer FSM with dwell counter, PC and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pc        <= '0;
            r_instrword <= '0;
            r_newinstr  <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_newinstr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    r_cnt <= '0;
                    if (opcode_of(w_rdata) == OP_HALT) begin
                        r_state  <= HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state     <= ISSUE;
                        r_instrword <= w_rdata;
                        r_newinstr  <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_cnt   <= 4'd1;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == c_dwell_last) begin
                        r_cnt   <= '0;
                        r_state <= FETCH;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                HALT: begin
                    if (start) begin
                        r_state  <= FETCH;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign instrword = r_instrword;
    assign newinstr  = r_newinstr;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign halted    = r_halted;

endmodule
`default_nettype wire
